// File: rtl/calc_result_display_if.sv
// rtl/calc_result_display_if.sv - calculator result / display signal bundle
interface calc_result_display_if;
   logic [15:0] result;
   logic        display_en;
   logic [19:0] bcd;
   logic        busy;
   logic [6:0]  seg;
   logic [4:0]  an;

   modport master (
      output result,
      output display_en,
      input  bcd,
      input  busy,
      input  seg,
      input  an
   );

   modport slave (
      input  result,
      input  display_en,
      output bcd,
      output busy,
      output seg,
      output an
   );
endinterface

// File: rtl/calc_result_display.sv
// rtl/calc_result_display.sv - binary-to-BCD converter with 5-digit 7-segment scan; optional CALC_DISP_LZB_EN blanking
module calc_result_display #(
   parameter int unsigned SCAN_DIV = 16
) (
   input  logic                  clk,
   input  logic                  clear_n,
   calc_result_display_if.slave  disp
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [15:0] PRES_LAST = 16'(SCAN_DIV - 1);

   state_t      state_q, state_d;
   logic [15:0] last_q, last_d;
   logic [15:0] sh_q, sh_d;
   logic [19:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [19:0] bcd_q, bcd_d;
   logic [19:0] acc_adj;

   logic [15:0] pres_q;
   logic [2:0]  idx_q;
   logic [3:0]  nib;
   logic [6:0]  seg_next;
   logic [4:0]  an_next;
   logic [6:0]  seg_q;
   logic [4:0]  an_q;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b1000000;
         4'd1:    p = 7'b1111001;
         4'd2:    p = 7'b0100100;
         4'd3:    p = 7'b0110000;
         4'd4:    p = 7'b0011001;
         4'd5:    p = 7'b0010010;
         4'd6:    p = 7'b0000010;
         4'd7:    p = 7'b1111000;
         4'd8:    p = 7'b0000000;
         4'd9:    p = 7'b0010000;
         default: p = 7'b1111111;
      endcase
      return p;
   endfunction

   // Add-3 correction of every accumulator nibble that would overflow past 9 when doubled
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < 5; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Converter next-state: capture on change, 16 shift steps, then publish the result
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      bcd_d   = bcd_q;
      case (state_q)
         IDLE: begin
            if (disp.result != last_q) begin
               last_d  = disp.result;
               sh_d    = disp.result;
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {acc_d, sh_d} = {acc_adj[18:0], sh_q, 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bcd_d   = acc_q;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Converter state and datapath registers
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= IDLE;
         last_q  <= '0;
         sh_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         bcd_q   <= bcd_d;
      end
   end

   // Free-running prescaler advances the digit index once per SCAN_DIV cycles
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         pres_q <= '0;
         idx_q  <= '0;
      end else if (pres_q == PRES_LAST) begin
         pres_q <= '0;
         idx_q  <= (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
      end else begin
         pres_q <= pres_q + 16'd1;
      end
   end

   // Select the published BCD nibble for the digit currently being scanned
   always_comb begin
      case (idx_q)
         3'd1:    nib = bcd_q[7:4];
         3'd2:    nib = bcd_q[11:8];
         3'd3:    nib = bcd_q[15:12];
         3'd4:    nib = bcd_q[19:16];
         default: nib = bcd_q[3:0];
      endcase
   end

`ifdef CALC_DISP_LZB_EN
   logic blank;

   // A digit is dark when it and every higher digit are zero; the units digit always shows
   always_comb begin
      case (idx_q)
         3'd1:    blank = (bcd_q[19:4]  == 16'd0);
         3'd2:    blank = (bcd_q[19:8]  == 12'd0);
         3'd3:    blank = (bcd_q[19:12] == 8'd0);
         3'd4:    blank = (bcd_q[19:16] == 4'd0);
         default: blank = 1'b0;
      endcase
   end

   assign seg_next = blank ? 7'b1111111 : seg_decode(nib);
`else
   assign seg_next = seg_decode(nib);
`endif

   assign an_next = disp.display_en ? ~(5'b00001 << idx_q) : 5'b11111;

   // Pattern and digit enable register together so they always switch on the same edge
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         seg_q <= 7'b1000000;
         an_q  <= 5'b11110;
      end else begin
         seg_q <= seg_next;
         an_q  <= an_next;
      end
   end

   assign disp.bcd  = bcd_q;
   assign disp.busy = busy_q;
   assign disp.seg  = seg_q;
   assign disp.an   = an_q;

endmodule

// File: tb/tb_calc_result_display.sv
// tb/tb_calc_result_display.sv - randomized self-checking bench against a cycle-level reference model
module tb_calc_result_display;

   localparam int SCAN_DIV = 4;

   logic clk = 1'b0;
   logic clear_n;

   calc_result_display_if bus();

   calc_result_display #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk     (clk),
      .clear_n (clear_n),
      .disp    (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: value-level view of converter and scanner
   int         m_cnt;     // cycles left in the current conversion, 0 = idle
   int         m_last;
   int         m_pend;
   int         m_val;     // integer value currently published on bcd
   int         m_t;       // edges since reset release
   logic [6:0] m_seg;
   logic [4:0] m_an;

   logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   int pow10 [5] = '{1, 10, 100, 1000, 10000};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [6:0] exp_seg(input int v, input int idx);
      int upper;
      upper = v / pow10[idx];
`ifdef CALC_DISP_LZB_EN
      if (idx > 0 && upper == 0) return 7'h7F;
`endif
      return pat[upper % 10];
   endfunction

   task automatic model_reset();
      m_cnt  = 0;
      m_last = 0;
      m_pend = 0;
      m_val  = 0;
      m_t    = 0;
      m_seg  = 7'h40;
      m_an   = 5'h1E;
   endtask

   task automatic model_edge(input int res, input bit en);
      int idx;
      idx   = (m_t / SCAN_DIV) % 5;
      m_seg = exp_seg(m_val, idx);
      m_an  = en ? (5'h1F ^ (5'd1 << idx)) : 5'h1F;
      m_t++;
      if (m_cnt == 0) begin
         if (res != m_last) begin
            m_last = res;
            m_pend = res;
            m_cnt  = 17;
         end
      end else begin
         m_cnt--;
         if (m_cnt == 0) m_val = m_pend;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".busy"}, 32'(bus.busy), 32'(m_cnt != 0));
      check({tag, ".bcd"},  32'(bus.bcd),  32'(to_bcd(m_val)));
      check({tag, ".seg"},  32'(bus.seg),  32'(m_seg));
      check({tag, ".an"},   32'(bus.an),   32'(m_an));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge(int'(bus.result), bus.display_en);
      @(negedge clk);
      compare_all(tag);
   endtask

   task automatic steps(input string tag, input int n);
      for (int k = 0; k < n; k++) step(tag);
   endtask

   task automatic do_reset(input string tag, input int cycles);
      #2;
      clear_n = 1'b0;
      #1;
      model_reset();
      compare_all({tag, ".now"});
      repeat (cycles) @(negedge clk);
      compare_all({tag, ".hold"});
      clear_n = 1'b1;
   endtask

   initial begin
      clear_n        = 1'b0;
      bus.result     = 16'd0;
      bus.display_en = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all("init");
      clear_n = 1'b1;

      // zero result: no conversion, full scan rotation
      steps("zero", 5 * SCAN_DIV + 4);
      check("zero.busy_const", 32'(bus.busy), 32'd0);

      // 0 -> 8
      bus.result = 16'd8;
      steps("eight", 20 + 5 * SCAN_DIV);
      check("eight.bcd_const", 32'(bus.bcd), 32'h00008);

      bus.result = 16'd65535;
      steps("max", 20);
      check("max.bcd_const", 32'(bus.bcd), 32'h65535);

      bus.result = 16'd16;
      steps("sixteen", 20);
      check("sixteen.bcd_const", 32'(bus.bcd), 32'h00016);

      bus.result = 16'd2;
      steps("two", 20);
      check("two.bcd_const", 32'(bus.bcd), 32'h00002);

      // change during conversion: 5 then 3 mid-shift
      bus.result = 16'd5;
      steps("chg5", 6);
      bus.result = 16'd3;
      steps("chg3", 40);
      check("chg.bcd_const", 32'(bus.bcd), 32'h00003);

      // reset in the middle of a conversion of 1234
      bus.result = 16'd1234;
      steps("r1234", 8);
      do_reset("rst", 3);
      steps("r1234b", 18);
      check("r1234.bcd_const", 32'(bus.bcd), 32'h01234);

      // LZB sample values with display enabled
      bus.result     = 16'd40;
      bus.display_en = 1'b1;
      steps("forty", 18 + 5 * SCAN_DIV);
      bus.result = 16'd0;
      steps("zero2", 18 + 5 * SCAN_DIV);

      // randomized values, hold times and display enable
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 3))
            0:       bus.result = 16'($urandom_range(0, 9));
            1:       bus.result = 16'($urandom_range(0, 999));
            default: bus.result = 16'($urandom);
         endcase
         bus.display_en = 1'($urandom_range(0, 1));
         steps("rand", $urandom_range(1, 24));
      end
      steps("drain", 20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/calc_result_display.md
CALC_RESULT_DISPLAY -- requirements
Module: calc_result_display

Interface
REQ-001 SCAN_DIV, 16, clock cycles each digit is held on the display (legal 2..65535).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 clear_n  in  1  asynchronous, active-low reset.
REQ-004 result  in  16  unsigned value from the calculator ALU stage; may change on any cycle.
REQ-005 display_en  in  1  1 = drive digit enables, 0 = all digits dark.
REQ-006 bcd  out  20  five packed BCD digits, [3:0] = units, [19:16] = ten-thousands; registered.
REQ-007 busy  out  1  1 while a binary-to-BCD conversion is in progress.
REQ-008 seg  out  7  active-low segments, seg[0]=a ... seg[6]=g.
REQ-009 an  out  5  active-low one-hot digit enables, an[0] = units digit.

Function
REQ-010 Converter SHALL be a sequential shift-and-add-3 FSM with states IDLE, SHIFT, DONE.
REQ-011 IDLE: on any edge where result != last_result, SHALL capture result into last_result and the shift register, clear the BCD accumulator, set busy=1, go to SHIFT.
REQ-012 SHIFT: SHALL run exactly 16 edges; each edge adds 3 to every accumulator nibble >= 5, then shifts the combined register left by one bit.
REQ-013 After the 16th SHIFT edge SHALL enter DONE; the DONE edge SHALL load bcd, clear busy and return to IDLE.
REQ-014 Latency: bcd SHALL update on the 17th edge after the capture edge; busy high for exactly 17 cycles.
REQ-015 result changes during SHIFT/DONE SHALL be ignored until IDLE, then detected by REQ-011 (no loss of the final value).
REQ-016 bcd SHALL hold its previous value throughout a conversion (no partial values visible).
REQ-017 Range 0..65535; conversion SHALL be exact over the full 16-bit range (65535 -> 20'h65535).
REQ-018 Scan: prescaler SHALL count 0..SCAN_DIV-1 continuously; at terminal count, digit index SHALL advance 0,1,2,3,4 and wrap to 0.
REQ-019 seg SHALL be the registered decode of bcd nibble [index]; an SHALL be registered ~(1<<index) when display_en=1, else 5'b11111.
REQ-020 seg/an SHALL change on the same edge (no ghosting between digit and pattern).
REQ-021 Decode SHALL map 0..9 to standard patterns (0 = 7'b1000000, 8 = 7'b0000000); nibble values 10..15 are impossible and SHALL decode to 7'b1111111.
REQ-022 display_en SHALL not stop the prescaler, scan index or converter.

Reset
REQ-023 clear_n low SHALL immediately force: state IDLE, busy 0, last_result 0, bcd 0, prescaler 0, index 0, seg 7'b1000000, an 5'b11110.
REQ-024 Reset during SHIFT SHALL abort the conversion with no bcd update; after release, a nonzero result SHALL start a fresh conversion on the first edge.
REQ-025 Release of clear_n SHALL be consumed synchronously; the first post-reset edge is a normal operating edge.

Configuration
REQ-026 Macro CALC_DISP_LZB_EN defined: leading-zero blanking; digits above the most significant nonzero digit SHALL output seg 7'b1111111; digit 0 never blanked.
REQ-027 CALC_DISP_LZB_EN undefined: all five digits SHALL display, zeros included; no blanking logic synthesized.

Verification
REQ-028 Reset, result=0, display_en=1 -> no conversion (busy stays 0), bcd 20'h00000, an cycles 11110,11101,11011,10111,01111,11110 every SCAN_DIV cycles.
REQ-029 result 0->8 -> busy high 17 cycles, bcd 20'h00008 on 17th edge; units digit seg 7'b0000000.
REQ-030 result=65535 -> bcd 20'h65535; result=16 -> 20'h00016; result=2 -> 20'h00002.
REQ-031 result 5->3 at 6th SHIFT cycle -> bcd 20'h00005 first, then second conversion, final bcd 20'h00003.
REQ-032 clear_n low mid-SHIFT of 1234 -> outputs at reset values immediately; after release bcd 20'h01234 17 edges after first capture edge.
REQ-033 CALC_DISP_LZB_EN defined, result=40 -> digits 2..4 seg 7'b1111111, digit1 shows 4, digit0 shows 0; result=0 -> only digit0 lit showing 0.
